sfx_arbiter: RTL
================

// Module: sfx_arbiter
// PURPOSE
//   Priority arbiter/scheduler for the single audio tone generator. Latches one-cycle sound-event
//   requests from game logic (car collision, edge collision, finish, bonus) and grants the tone
//   generator to one event at a time. Each granted event plays for a fixed number of frames.
//   The arbiter then inserts a silent gap before the next event.
//   Sits between game-state/collision logic and the tone generator (sound code + enable).
// PARAMETERS
//   NUM_REQ    4                  number of requesters; index 0 = highest priority
//   CODE_W     4                  width of tone code
//   DUR_W      5                  width of duration counter (frames)
//   REQ_CODES  {4'h7,4'h6,4'h3,4'h4}  packed tone codes, req[i] -> bits [i*CODE_W +: CODE_W]
//   REQ_DURS   {5'd5,5'd4,5'd3,5'd3}  packed play durations in frames, same packing
//   GAP_FRAMES 1                  silent frames between consecutive events; 0 = no gap
// PORTS
//   clk          in   1               system clock
//   resetN       in   1               synchronous active-low reset
//   frame_start  in   1               one-cycle pulse per video frame; the arbiter's time base
//   req          in   NUM_REQ         one-cycle event pulses (0 car coll, 1 edge coll, 2 finish, 3 bonus)
//   sound        out  CODE_W          tone code to generator; 0 = silence
//   enable_sound out  1               high while an event is playing
//   active_id    out  $clog2(NUM_REQ) index of playing event; 0 when idle
//   busy         out  1               high in PLAY or GAP
//   preempted    out  1               one-cycle pulse when a playing event is aborted by a higher priority one
// BEHAVIOUR
//   Reset (resetN low at posedge clk):
//     - Outputs: sound=0, enable_sound=0, active_id=0, busy=0, preempted=0.
//     - State: pending=0, state=IDLE, counters=0.
//   Pending:
//     - pending[i] is set on the edge after req[i]=1.
//     - pending[i] is cleared on the edge where i is granted.
//     - If set and clear hit the same bit on the same edge, set wins.
//     - Repeat requests while pending[i] is already set are merged.
//   Grant: lowest-index set pending bit (fixed priority). All outputs are registered.
//   Latency: a req pulse in cycle N, with the arbiter idle, gives sound/enable_sound valid from cycle N+2.
//   FSM states:
//     IDLE
//       - Any pending bit set -> PLAY.
//       - On entry to PLAY: load dur_cnt = REQ_DURS[g] (a table value of 0 is treated as 1).
//       - Drive sound = REQ_CODES[g], enable_sound=1, active_id=g.
//     PLAY
//       - On frame_start, dur_cnt decrements.
//       - frame_start with dur_cnt==1 -> GAP if GAP_FRAMES>0, else IDLE.
//       - On leaving PLAY: sound=0, enable_sound=0.
//       - Preemption: if any pending[j] with j < active_id is set, on the next edge the arbiter
//         reloads for j and pulses preempted. It stays in PLAY.
//       - The aborted event is dropped, not resumed.
//       - A pending bit with index >= active_id waits; this includes a re-request of the active index.
//     GAP
//       - gap_cnt is loaded with GAP_FRAMES on entry; sound=0, enable_sound=0.
//       - frame_start decrements gap_cnt; frame_start with gap_cnt==1 -> IDLE.
//       - No preemption in GAP.
//       - Next-grant latency after IDLE is 1 cycle. IDLE does not wait for frame_start.
//   Counter timing:
//     - frame_start in the same cycle as a load (grant or preempt) is ignored; the counter loads
//       the full value.
//     - Play time is therefore dur frames (partial first frame counted).
//   busy = (state != IDLE). active_id keeps its value through GAP and is zeroed on return to IDLE.
//   Simultaneous multiple reqs: all are latched and served in priority order, one per PLAY.
//   Mid-operation reset: clears everything on that edge. No event survives reset.
// TESTING
//   1. Reset, then req[3] pulse at cycle 10 -> sound=4'h7, enable_sound=1 from cycle 12.
//      After 5 frame_starts, sound=0; busy drops after 1 more frame_start.
//   2. req[3] and req[0] pulsed in the same cycle -> 4'h4 plays for 3 frames, then a 1-frame gap,
//      then 4'h7 for 5 frames. preempted never pulses.
//   3. req[2] playing (4'h6, dur_cnt=3), req[1] pulse -> 2 cycles later sound=4'h3 and preempted
//      pulses for 1 cycle. Event 2 is never replayed.
//   4. req[1] playing, then req[3] and a second req[1] arrive -> no preemption. Next events are
//      4'h3 again, then 4'h7.
//   5. frame_start asserted in the grant cycle of req[0] -> exactly 3 further frame_starts are
//      needed to end PLAY.
//   6. resetN low for 1 cycle during PLAY with pending[3] set -> next cycle all outputs are 0,
//      and no sound occurs without a new req.

Source files
------------

// File: rtl/sfx_arbiter.sv
// -----------------------------------------------------------------------------
// sfx_arbiter
//   Fixed-priority arbiter/scheduler for the single audio tone generator.
//   Game logic fires one-cycle sound-event requests; each one is latched into a
//   pending bit. One event at a time gets the tone generator and plays for a
//   fixed number of video frames. A silent gap of GAP_FRAMES frames follows
//   each event. A pending event with higher priority than the one playing
//   aborts the current event, which is dropped.
//
// Ports
//   clk          in   1        system clock
//   resetN       in   1        synchronous active-low reset
//   frame_start  in   1        one-cycle pulse per video frame (time base)
//   req          in   NUM_REQ  one-cycle event pulses, index 0 = highest priority
//   sound        out  CODE_W   tone code to the generator, 0 = silence
//   enable_sound out  1        high while an event is playing
//   active_id    out  ID_W     index of the playing event, 0 when idle
//   busy         out  1        high in PLAY or GAP
//   preempted    out  1        one-cycle pulse when a playing event is aborted
// -----------------------------------------------------------------------------
module sfx_arbiter #(
  parameter int                     NUM_REQ    = 4,
  parameter int                     CODE_W     = 4,
  parameter int                     DUR_W      = 5,
  parameter logic [NUM_REQ*CODE_W-1:0] REQ_CODES = {4'h7, 4'h6, 4'h3, 4'h4},
  parameter logic [NUM_REQ*DUR_W-1:0]  REQ_DURS  = {5'd5, 5'd4, 5'd3, 5'd3},
  parameter int                     GAP_FRAMES = 1,
  localparam int                    ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              frame_start,
  input  logic [NUM_REQ-1:0] req,
  output logic [CODE_W-1:0] sound,
  output logic              enable_sound,
  output logic [ID_W-1:0]   active_id,
  output logic              busy,
  output logic              preempted
);

  // Gap counter is sized to hold GAP_FRAMES (at least one bit wide).
  localparam int GAP_W    = $clog2(GAP_FRAMES + 2);
  localparam bit HAS_GAP  = (GAP_FRAMES > 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Table lookups and priority encoding
  // ---------------------------------------------------------------------------

  // Play duration for an event; a table entry of zero still plays one frame.
  function automatic logic [DUR_W-1:0] dur_of(input logic [ID_W-1:0] idx);
    logic [DUR_W-1:0] d;
    d = REQ_DURS[int'(idx) * DUR_W +: DUR_W];
    if (d == {DUR_W{1'b0}}) begin
      return {{(DUR_W-1){1'b0}}, 1'b1};
    end else begin
      return d;
    end
  endfunction

  // Tone code for an event.
  function automatic logic [CODE_W-1:0] code_of(input logic [ID_W-1:0] idx);
    return REQ_CODES[int'(idx) * CODE_W +: CODE_W];
  endfunction

  // Lowest set index of a request vector (0 when none is set).
  function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_REQ-1:0] vec);
    logic [ID_W-1:0] idx;
    idx = {ID_W{1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = ID_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_r;
  logic [NUM_REQ-1:0]  pending_r;
  logic [DUR_W-1:0]    dur_cnt_r;
  logic [GAP_W-1:0]    gap_cnt_r;
  logic [ID_W-1:0]     active_id_r;
  logic [CODE_W-1:0]   sound_r;
  logic                enable_r;
  logic                busy_r;
  logic                preempted_r;

  state_t              state_s;
  logic [NUM_REQ-1:0]  pending_s;
  logic [NUM_REQ-1:0]  clear_s;
  logic [DUR_W-1:0]    dur_cnt_s;
  logic [GAP_W-1:0]    gap_cnt_s;
  logic [ID_W-1:0]     active_id_s;
  logic [CODE_W-1:0]   sound_s;
  logic                enable_s;
  logic                busy_s;
  logic                preempt_s;

  logic                has_pend_s;
  logic [ID_W-1:0]     low_idx_s;

  assign has_pend_s = |pending_r;
  assign low_idx_s  = lowest_set(pending_r);

  // Next-state, counters, pending bookkeeping and next output values.
  always_comb begin
    state_s     = state_r;
    dur_cnt_s   = dur_cnt_r;
    gap_cnt_s   = gap_cnt_r;
    active_id_s = active_id_r;
    preempt_s   = 1'b0;
    clear_s     = {NUM_REQ{1'b0}};

    case (state_r)
      ST_IDLE: begin
        // Grant immediately; frame_start in this cycle is irrelevant because
        // the duration counter is loaded with the full value.
        if (has_pend_s) begin
          state_s            = ST_PLAY;
          active_id_s        = low_idx_s;
          dur_cnt_s          = dur_of(low_idx_s);
          clear_s[low_idx_s] = 1'b1;
        end else begin
          state_s     = ST_IDLE;
          active_id_s = {ID_W{1'b0}};
        end
      end

      ST_PLAY: begin
        // The lowest pending index is below active_id only when a strictly
        // higher-priority event is waiting; equal or lower ones keep waiting.
        if (has_pend_s && (low_idx_s < active_id_r)) begin
          active_id_s        = low_idx_s;
          dur_cnt_s          = dur_of(low_idx_s);
          clear_s[low_idx_s] = 1'b1;
          preempt_s          = 1'b1;
        end else if (frame_start) begin
          if (dur_cnt_r <= {{(DUR_W-1){1'b0}}, 1'b1}) begin
            dur_cnt_s = {DUR_W{1'b0}};
            if (HAS_GAP) begin
              state_s   = ST_GAP;
              gap_cnt_s = GAP_W'(GAP_FRAMES);
            end else begin
              state_s     = ST_IDLE;
              active_id_s = {ID_W{1'b0}};
            end
          end else begin
            dur_cnt_s = dur_cnt_r - {{(DUR_W-1){1'b0}}, 1'b1};
          end
        end else begin
          dur_cnt_s = dur_cnt_r;
        end
      end

      ST_GAP: begin
        // active_id is held through the gap and cleared on return to IDLE.
        if (frame_start) begin
          if (gap_cnt_r <= {{(GAP_W-1){1'b0}}, 1'b1}) begin
            state_s     = ST_IDLE;
            gap_cnt_s   = {GAP_W{1'b0}};
            active_id_s = {ID_W{1'b0}};
          end else begin
            gap_cnt_s = gap_cnt_r - {{(GAP_W-1){1'b0}}, 1'b1};
          end
        end else begin
          gap_cnt_s = gap_cnt_r;
        end
      end

      default: begin
        state_s     = ST_IDLE;
        dur_cnt_s   = {DUR_W{1'b0}};
        gap_cnt_s   = {GAP_W{1'b0}};
        active_id_s = {ID_W{1'b0}};
      end
    endcase

    // A new request on the bit being granted re-arms it (set wins).
    pending_s = (pending_r & ~clear_s) | req;

    if (state_s == ST_PLAY) begin
      sound_s  = code_of(active_id_s);
      enable_s = 1'b1;
    end else begin
      sound_s  = {CODE_W{1'b0}};
      enable_s = 1'b0;
    end
    busy_s = (state_s != ST_IDLE);
  end

  // State, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_r     <= ST_IDLE;
      pending_r   <= {NUM_REQ{1'b0}};
      dur_cnt_r   <= {DUR_W{1'b0}};
      gap_cnt_r   <= {GAP_W{1'b0}};
      active_id_r <= {ID_W{1'b0}};
      sound_r     <= {CODE_W{1'b0}};
      enable_r    <= 1'b0;
      busy_r      <= 1'b0;
      preempted_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      pending_r   <= pending_s;
      dur_cnt_r   <= dur_cnt_s;
      gap_cnt_r   <= gap_cnt_s;
      active_id_r <= active_id_s;
      sound_r     <= sound_s;
      enable_r    <= enable_s;
      busy_r      <= busy_s;
      preempted_r <= preempt_s;
    end
  end

  assign sound        = sound_r;
  assign enable_sound = enable_r;
  assign active_id    = active_id_r;
  assign busy         = busy_r;
  assign preempted    = preempted_r;

endmodule
